// File: rtl/axi_gen_arb.sv
// rtl/axi_gen_arb.sv - round-robin frame arbiter driving a data generator with watchdog
module axi_gen_arb #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*10-1:0]   req_length,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      done,
    output logic                    gen_start,
    output logic [9:0]              gen_length,
    input  logic                    mon_valid,
    input  logic                    mon_last,
    output logic                    busy,
    output logic [15:0]             frame_cnt,
    output logic                    err_zero_len,
    output logic                    err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CW    = IDX_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    // GAP is left when the counter reaches zero, so it is loaded with one less than its length
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_GAP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] sel_next;
    logic [CW-1:0]    cand;
    logic             sel_found;
    logic [9:0]       len_arr [NUM_REQ];
    logic [9:0]       sel_len;
    logic             sel_zero;
    logic             grant;
    logic             frame_end;
    logic             wd_expire;
    logic [WD_W-1:0]  wd_cnt;
    logic [3:0]       gap_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_len
            assign len_arr[gi] = req_length[10*gi +: 10];
        end
    endgenerate

    // Round-robin pick: scan from rr_ptr downward in priority so the closest index after rr_ptr wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (req_valid[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign sel_len   = len_arr[sel_idx];
    assign sel_zero  = (sel_len == 10'd0);
    assign sel_next  = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
    assign grant     = (state == S_IDLE) && sel_found && !rst;
    assign frame_end = (state == S_RUN) && mon_valid && mon_last;
    assign wd_expire = (state == S_RUN) && !mon_valid && (wd_cnt == WD_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; zero-length grants never leave IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant && !sel_zero) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN:   if (frame_end || wd_expire) state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (gap_cnt == 4'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Combinational outputs, forced low while rst is high
    always_comb begin
        req_ready = '0;
        gen_start = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            if (grant) begin
                req_ready[sel_idx] = 1'b1;
            end
            gen_start = (state == S_START);
            busy      = (state != S_IDLE);
        end
    end

    // Datapath: grant latching, watchdog, gap counter and registered completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            idx          <= '0;
            gen_length   <= '0;
            wd_cnt       <= '0;
            gap_cnt      <= '0;
            done         <= '0;
            err_zero_len <= 1'b0;
            err_timeout  <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            done         <= '0;
            err_zero_len <= 1'b0;
            err_timeout  <= 1'b0;
            if (grant) begin
                idx        <= sel_idx;
                gen_length <= sel_len;
                rr_ptr     <= sel_next;
                if (sel_zero) begin
                    err_zero_len  <= 1'b1;
                    done[sel_idx] <= 1'b1;
                end
            end
            if (state == S_RUN && !mon_valid) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (frame_end) begin
                done[idx] <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (wd_expire) begin
                done[idx]   <= 1'b1;
                err_timeout <= 1'b1;
            end
            if (state == S_RUN && state_nxt == S_GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == S_GAP && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: doc/axi_gen_arb.md
AXI_GEN_ARB -- requirements
Module: axi_gen_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of frame requesters; range 2..8.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted after each frame; range 0..15.
REQ-003 Parameter TIMEOUT, default 1024: maximum idle cycles in RUN without a monitored beat.
REQ-004 clk  in  1  clock; all logic is single-clock and posedge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  requester i holds high while a frame request is pending.
REQ-007 req_length  in  NUM_REQ*10  frame byte length of requester i at bits [10i+9:10i]; held stable while req_valid[i] is high.
REQ-008 req_ready  out  NUM_REQ  one-cycle grant pulse that consumes requester i's request.
REQ-009 done  out  NUM_REQ  one-cycle pulse when requester i's frame completes or aborts.
REQ-010 gen_start  out  1  one-cycle start pulse to the data generator.
REQ-011 gen_length  out  10  byte length for the generator; held constant from START through RUN.
REQ-012 mon_valid  in  1  generator beat accepted; already qualified by downstream ready.
REQ-013 mon_last  in  1  final beat of a frame; meaningful only when mon_valid is high.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_cnt  out  16  count of completed frames; wraps from 0xFFFF to 0.
REQ-016 err_zero_len  out  1  one-cycle pulse when a zero-length request is rejected.
REQ-017 err_timeout  out  1  one-cycle pulse when a frame is aborted by the watchdog.

Function
REQ-018 The FSM SHALL have the states IDLE, START, RUN and GAP.
REQ-019 IDLE SHALL select a requester when any req_valid bit is high:
- selection is round-robin, starting at the index after the last granted index (index 0 first after reset);
- in the selection cycle, req_ready[idx] pulses, idx is latched, and gen_length is latched from req_length[idx].
REQ-020 A granted request with length 0 SHALL be handled without starting the generator:
- err_zero_len and done[idx] pulse in the cycle after the grant;
- the FSM stays in IDLE and the round-robin pointer advances.
REQ-021 A granted request with non-zero length SHALL move the FSM to START, where gen_start is high for exactly one cycle before the FSM enters RUN.
REQ-022 RUN SHALL end on the cycle with mon_valid=1 and mon_last=1:
- done[idx] pulses and frame_cnt increments in the following cycle;
- the FSM then goes to GAP, or directly to IDLE when GAP_CYCLES=0.
REQ-023 The RUN watchdog SHALL behave as follows:
- it counts cycles in RUN and clears on every mon_valid;
- when it reaches TIMEOUT, err_timeout and done[idx] pulse, frame_cnt is not incremented, and the FSM goes to GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, and the FSM then returns to IDLE.
REQ-025 Any req_valid bit that is high during START, RUN or GAP SHALL be left pending; no req_ready pulse is issued in those states.
REQ-026 mon_valid and mon_last SHALL be ignored outside RUN.
REQ-027 At most one req_ready bit and at most one done bit SHALL be high in any cycle.
REQ-028 The minimum frame-to-frame spacing SHALL be: grant -> START (1 cycle) -> RUN -> last beat -> GAP -> IDLE -> next grant.

Reset
REQ-029 While rst is high, the FSM SHALL go to IDLE and the round-robin pointer SHALL point to index 0.
REQ-030 While rst is high, the outputs SHALL be:
- 0: req_ready, done, gen_start, busy, err_zero_len, err_timeout;
- 0: frame_cnt, gen_length.
REQ-031 Asserting rst mid-frame SHALL abort the frame with no done pulse, and the first grant after reset SHALL be evaluated starting at index 0.

Verification
REQ-032 Single frame: req_valid=0001, len=20, mon_last on the 3rd beat -> req_ready[0], then gen_start=1 and gen_length=20; done[0] and frame_cnt=1 one cycle after the last beat; busy low after 2 GAP cycles.
REQ-033 Round-robin: req_valid=1111 held, each frame 8 bytes -> grant order 0,1,2,3,0; every grant separated by a completed frame plus the GAP.
REQ-034 Zero length: req_valid=0100, len=0 -> req_ready[2], then err_zero_len and done[2] one cycle later; gen_start never asserted; frame_cnt unchanged.
REQ-035 Watchdog: TIMEOUT=16 and mon_valid held 0 in RUN -> err_timeout and done[idx] after 16 RUN cycles; frame_cnt unchanged; next grant follows the GAP.
REQ-036 Reset mid-RUN: rst pulsed with req_valid=1010 -> all outputs 0, no done pulse; after reset the first grant goes to index 1.
REQ-037 Wrap: frame_cnt preloaded to 0xFFFF via 65535 frames (or a force) -> the next completion gives frame_cnt=0x0000.
